// File: rtl/imem_loader_if.sv
// Stream-side and memory-write-side signals of the instruction-memory loader.
// The host/testbench holds the master modport; the loader holds the slave modport.
interface imem_loader_if;
    // Host byte stream and session control
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;

    // Instruction-memory write port
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // Core control and session status
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  busy,
        input  done,
        input  error,
        input  words_written
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output busy,
        output done,
        output error,
        output words_written
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (LEN_HI, LEN_LO, 4*N
// big-endian payload bytes, CHK), writes each assembled word into instruction
// memory and keeps the core held until a load finishes with a good checksum.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;        // frame length in words
    logic [1:0]  idx_q, idx_d;        // byte position inside the current word
    logic [23:0] shift_q, shift_d;    // first three bytes of the word being assembled
    logic [7:0]  sum_q, sum_d;        // running payload checksum
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;

    logic        in_ready;
    logic        accept;
    logic [15:0] len_full;
    logic [7:0]  sum_next;
    logic [15:0] words_inc;

    // Ready depends on state alone, so it never loops back through in_valid.
    // The done cycle is already IDLE, which also keeps ready low there.
    assign in_ready  = (state_q != IDLE);
    assign accept    = bus.in_valid && in_ready;
    assign len_full  = {len_q[15:8], bus.in_data};
    assign sum_next  = sum_q + bus.in_data;
    assign words_inc = words_q + 16'd1;

    // Next-state and output decode for the framing FSM.
    always_comb begin
        // NOTE: every _d signal gets its hold/default value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        error_d = error_q;
        words_d = words_q;

        unique case (state_q)
            IDLE: begin
                // A start landing on the done cycle is dropped along with any start while busy.
                if (bus.start && !done_q) begin
                    state_d = LEN_HI;
                    hold_d  = 1'b1;
                    error_d = 1'b0;
                    words_d = 16'd0;
                    sum_d   = 8'd0;
                    idx_d   = 2'd0;
                end
            end

            LEN_HI: begin
                if (accept) begin
                    len_d   = {bus.in_data, 8'h00};
                    state_d = LEN_LO;
                end
            end

            LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > DEPTH) begin
                        // Frame cannot fit in memory: abort before any write.
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (len_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    sum_d = sum_next;
                    if (idx_q == 2'd3) begin
                        // Fourth byte completes the word; the write pulse shows up next cycle
                        // while the next word's first byte can already be accepted.
                        we_d    = 1'b1;
                        wdata_d = {shift_q, bus.in_data};
                        addr_d  = BASE_ADDR + (32'(words_q) << 2);
                        words_d = words_inc;
                        idx_d   = 2'd0;
                        if (words_inc == len_q) begin
                            state_d = CHECK;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], bus.in_data};
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end

            CHECK: begin
                if (accept) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (sum_next == 8'd0) begin
                        hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
            sum_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
            words_q <= words_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.imem_we       = we_q;
    assign bus.imem_addr     = addr_q;
    assign bus.imem_wdata    = wdata_q;
    assign bus.cpu_hold      = hold_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: drives framed byte streams (directed
// and $urandom-generated) and compares writes and status against a frame-level
// reference model.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    int   done_cnt;
    wr_t  obs_w[$];
    wr_t  exp_w[$];
    bit   exp_err;
    bit   exp_hold;
    logic [15:0] exp_words;

    imem_loader_if bus();

    imem_loader #(
        .ADDR_WIDTH(8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write pulse and done pulse seen on the DUT outputs.
    always @(negedge clk) begin
        if (!reset && bus.imem_we === 1'b1) obs_w.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
        if (!reset && bus.done === 1'b1) done_cnt++;
    end

    // Reference model: expected writes and final flags computed from the frame bytes.
    task automatic build_model(input byte_q_t f);
        int n;
        int sum;
        logic [31:0] word;
        exp_w.delete();
        n = int'({f[0], f[1]});
        if (n > DEPTH) begin
            exp_err   = 1'b1;
            exp_hold  = 1'b1;
            exp_words = 16'd0;
            return;
        end
        sum = 0;
        for (int k = 0; k < n; k++) begin
            word = {f[2+4*k], f[3+4*k], f[4+4*k], f[5+4*k]};
            exp_w.push_back('{addr: BASE + 32'(4*k), data: word});
            for (int j = 0; j < 4; j++) sum += int'(f[2+4*k+j]);
        end
        sum += int'(f[2+4*n]);
        exp_err   = (sum % 256) != 0;
        exp_hold  = exp_err;
        exp_words = 16'(n);
    endtask

    function automatic byte_q_t make_frame(input int n, input bit good);
        byte_q_t f;
        int sum;
        logic [7:0] b;
        logic [15:0] nl;
        nl = 16'(n);
        f.push_back(nl[15:8]);
        f.push_back(nl[7:0]);
        sum = 0;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back(b);
            sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if (!good) b = b + 8'($urandom_range(1, 255));
        f.push_back(b);
        return f;
    endfunction

    task automatic start_session();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offer one byte after an idle gap; optionally pulse start during the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int budget;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Run one complete session and compare it against the model.
    task automatic run_frame(input byte_q_t f, input int max_gap, input bit poke, input string name);
        int c0;
        build_model(f);
        obs_w.delete();
        done_cnt = 0;
        start_session();
        c0 = cyc;
        total++;
        if (bus.busy !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.error !== 1'b0 || bus.words_written !== 16'd0) begin
            bad++;
            $display("FAIL %s session_start: busy=%b hold=%b err=%b words=%0d required 1 1 0 0",
                     name, bus.busy, bus.cpu_hold, bus.error, bus.words_written);
        end
        foreach (f[i]) send_byte(f[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0, poke);
        // Now in the cycle after the final byte was taken: done must be up.
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s done: got %b required 1", name, bus.done);
        end
        total++;
        if (bus.error !== exp_err || bus.cpu_hold !== exp_hold || bus.words_written !== exp_words) begin
            bad++;
            $display("FAIL %s flags: err=%b hold=%b words=%0d required %b %b %0d",
                     name, bus.error, bus.cpu_hold, bus.words_written, exp_err, exp_hold, exp_words);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s done_cycle: busy=%b in_ready=%b required 0 0", name, bus.busy, bus.in_ready);
        end
        if (max_gap == 0) begin
            total++;
            if (cyc - c0 != f.size()) begin
                bad++;
                $display("FAIL %s throughput: cycles=%0d required %0d", name, cyc - c0, f.size());
            end
        end
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, bus.done, bus.busy);
        end
        repeat (2) @(negedge clk);
        total++;
        if (obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            total++;
            if (obs_w[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL %s write[%0d]: got addr=%h data=%h required addr=%h data=%h",
                         name, i, obs_w[i].addr, obs_w[i].data, exp_w[i].addr, exp_w[i].data);
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.error !== 1'b0 || bus.words_written !== 16'd0 ||
            bus.imem_addr !== BASE || bus.imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL %s: rdy=%b we=%b hold=%b busy=%b done=%b err=%b words=%0d addr=%h wdata=%h required 0 0 1 0 0 0 0 %h 0",
                     name, bus.in_ready, bus.imem_we, bus.cpu_hold, bus.busy, bus.done, bus.error,
                     bus.words_written, bus.imem_addr, bus.imem_wdata, BASE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_idle_ignores_bytes();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_bytes: in_ready=%b busy=%b required 0 0", bus.in_ready, bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        byte_q_t f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h59};
        run_frame(f, 0, 1'b0, "nominal");
    endtask

    task automatic test_bad_checksum();
        byte_q_t f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h58};
        run_frame(f, 0, 1'b0, "bad_chk");
    endtask

    task automatic test_oversize();
        byte_q_t f = '{8'h01, 8'h01};
        run_frame(f, 0, 1'b0, "oversize");
    endtask

    task automatic test_zero_length();
        byte_q_t f = '{8'h00, 8'h00, 8'h00};
        run_frame(f, 0, 1'b0, "zero_len");
    endtask

    task automatic test_full_depth();
        run_frame(make_frame(DEPTH, 1'b1), 0, 1'b0, "full_depth");
    endtask

    task automatic test_gaps_and_start();
        byte_q_t f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h59};
        run_frame(f, 5, 1'b1, "gaps_start");
    endtask

    task automatic test_reset_mid_word();
        // C8 brings DE+AD+BE+EF+CHK to zero mod 256.
        byte_q_t partial = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        byte_q_t full    = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC8};
        obs_w.delete();
        start_session();
        foreach (partial[i]) send_byte(partial[i], 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset_mid_word");
        total++;
        if (obs_w.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_word partial_write: got %0d writes required 0", obs_w.size());
        end
        run_frame(full, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            run_frame(make_frame($urandom_range(0, 6), 1'($urandom_range(0, 1))),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        done_cnt     = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_idle_ignores_bytes();
        test_nominal();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_gaps_and_start();
        test_reset_mid_word();
        test_full_depth();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
